// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush sequencer for the 5-stage RV32I pipeline. It arbitrates
//            halt, data-memory wait, branch redirect and load-use requests into
//            per-stage enable/flush/bubble controls. Optional performance
//            counters are built when PIPE_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 200,
  parameter int TO_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load_use,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ack,
  input  logic        i_branch_taken,
  input  logic        i_halt,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_en,
  output logic        o_id_ex_bubble,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_bubble,
  output logic        o_halted,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam bit              TO_ENABLE = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST   = TO_ENABLE ? TO_W'(MEM_TIMEOUT - 1) : '0;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            use_res;
  logic            halted;
  logic            mem_to;

  // Resolution of branch / load-use, shared by RUN and the ack cycle of MEM_WAIT
  logic res_pc_en, res_if_id_en, res_if_id_flush;
  logic res_id_ex_bubble, res_ex_mem_en;

  always_comb begin
    res_pc_en        = 1'b1;
    res_if_id_en     = 1'b1;
    res_if_id_flush  = 1'b0;
    res_id_ex_bubble = 1'b0;
    res_ex_mem_en    = 1'b1;
    if (i_branch_taken) begin
      res_if_id_flush  = 1'b1;
      res_id_ex_bubble = 1'b1;
    end else if (i_load_use) begin
      res_pc_en        = 1'b0;
      res_if_id_en     = 1'b0;
      res_id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    o_pc_en         = 1'b0;
    o_if_id_en      = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_en      = 1'b0;
    o_id_ex_bubble  = 1'b0;
    o_ex_mem_en     = 1'b0;
    o_mem_wb_bubble = 1'b0;
    use_res         = 1'b0;
    to_hit          = 1'b0;
    state_nxt       = state;
    case (state)
      BOOT: begin
        o_if_id_flush   = 1'b1;
        o_id_ex_bubble  = 1'b1;
        o_mem_wb_bubble = 1'b1;
        state_nxt       = RUN;
      end
      RUN: begin
        if (i_halt) begin
          state_nxt = HALTED;
        end else if (i_dmem_req && !i_dmem_ack) begin
          o_mem_wb_bubble = 1'b1;
          state_nxt       = MEM_WAIT;
        end else begin
          use_res = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ack) begin
          use_res   = 1'b1;
          state_nxt = RUN;
        end else begin
          o_mem_wb_bubble = 1'b1;
          if (TO_ENABLE && (to_cnt == TO_LAST)) begin
            to_hit    = 1'b1;
            state_nxt = HALTED;
          end
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
    if (use_res) begin
      o_pc_en        = res_pc_en;
      o_if_id_en     = res_if_id_en;
      o_if_id_flush  = res_if_id_flush;
      o_id_ex_en     = 1'b1;
      o_id_ex_bubble = res_id_ex_bubble;
      o_ex_mem_en    = res_ex_mem_en;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= BOOT;
      to_cnt <= '0;
      halted <= 1'b0;
      mem_to <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MEM_WAIT && !i_dmem_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      if (state_nxt == HALTED) begin
        halted <= 1'b1;
      end
      if (to_hit) begin
        mem_to <= 1'b1;
      end
    end
  end

  assign o_halted      = halted;
  assign o_mem_timeout = mem_to;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        flush_fire;

  assign flush_fire = use_res && i_branch_taken;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == RUN || state == MEM_WAIT) && !o_pc_en) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_fire) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_cnt;
  assign o_flush_count  = flush_cnt;
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// Testbench for pipeline_ctrl: vector table plus reset/timeout sequences,
// expectations queued at drive time and compared when outputs are sampled.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_use, dmem_req, dmem_ack, branch_taken, halt;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic        ex_mem_en, mem_wb_bubble, halted, mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_use     (load_use),
    .i_dmem_req     (dmem_req),
    .i_dmem_ack     (dmem_ack),
    .i_branch_taken (branch_taken),
    .i_halt         (halt),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_en     (id_ex_en),
    .o_id_ex_bubble (id_ex_bubble),
    .o_ex_mem_en    (ex_mem_en),
    .o_mem_wb_bubble(mem_wb_bubble),
    .o_halted       (halted),
    .o_mem_timeout  (mem_timeout),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, halted}
  localparam logic [7:0] C_BOOT = 8'b00101010;
  localparam logic [7:0] C_NORM = 8'b11010100;
  localparam logic [7:0] C_LU   = 8'b00011100;
  localparam logic [7:0] C_BR   = 8'b11111100;
  localparam logic [7:0] C_MS   = 8'b00000010;
  localparam logic [7:0] C_HIN  = 8'b00000000;
  localparam logic [7:0] C_HLT  = 8'b00000001;

  typedef struct {
    logic       lu, req, ack, br, hlt;
    logic [7:0] ctl;
    logic       to;
    logic       chk_perf;
    int         stall;
    int         flush;
  } vec_t;

  vec_t tbl [21];
  vec_t sb  [$];
  int   checks = 0;
  int   errors = 0;

  function automatic int perf_exp(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle right after a negedge, sample mid-cycle, then advance.
  task automatic step(input string name, input vec_t v);
    vec_t e;
    load_use     = v.lu;
    dmem_req     = v.req;
    dmem_ack     = v.ack;
    branch_taken = v.br;
    halt         = v.hlt;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    check({name, ".ctl"}, {24'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                           ex_mem_en, mem_wb_bubble, halted}, {24'd0, e.ctl});
    check({name, ".mem_timeout"}, {31'd0, mem_timeout}, {31'd0, e.to});
    if (e.chk_perf) begin
      check({name, ".stall_cycles"}, stall_cycles, perf_exp(e.stall));
      check({name, ".flush_count"}, flush_count, perf_exp(e.flush));
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic lu, req, ack, br, hlt, input logic [7:0] ctl,
                              input logic to, input logic cp, input int st, input int fl);
    vec_t v;
    v.lu = lu; v.req = req; v.ack = ack; v.br = br; v.hlt = hlt;
    v.ctl = ctl; v.to = to; v.chk_perf = cp; v.stall = st; v.flush = fl;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    load_use = 0; dmem_req = 0; dmem_ack = 0; branch_taken = 0; halt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //            lu req ack br hlt  ctl    to cp stall flush
    tbl[0]  = mk(0, 0, 0, 0, 0, C_BOOT, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, C_LU,   0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 1, 0, C_BR,   0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 1, 1);
    tbl[6]  = mk(0, 1, 1, 0, 0, C_NORM, 0, 1, 1, 1);
    tbl[7]  = mk(0, 1, 0, 1, 0, C_MS,   0, 1, 1, 1);
    tbl[8]  = mk(0, 1, 0, 1, 0, C_MS,   0, 1, 2, 1);
    tbl[9]  = mk(0, 1, 0, 1, 0, C_MS,   0, 1, 3, 1);
    tbl[10] = mk(0, 1, 1, 1, 0, C_BR,   0, 1, 4, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 4, 2);
    tbl[12] = mk(1, 1, 0, 0, 0, C_MS,   0, 1, 4, 2);
    tbl[13] = mk(1, 1, 1, 0, 0, C_LU,   0, 1, 5, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 6, 2);
    tbl[15] = mk(0, 1, 0, 0, 0, C_MS,   0, 1, 6, 2);
    tbl[16] = mk(0, 1, 0, 0, 1, C_MS,   0, 1, 7, 2);
    tbl[17] = mk(0, 1, 1, 0, 0, C_NORM, 0, 1, 8, 2);
    tbl[18] = mk(0, 0, 0, 0, 1, C_HIN,  0, 1, 8, 2);
    tbl[19] = mk(0, 0, 0, 0, 0, C_HLT,  0, 1, 9, 2);
    tbl[20] = mk(1, 1, 0, 1, 0, C_HLT,  0, 1, 9, 2);

    rst_n = 1'b0;
    load_use = 0; dmem_req = 0; dmem_ack = 0; branch_taken = 0; halt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Memory timeout: RUN stall cycle plus four MEM_WAIT cycles, then sticky halt
    do_reset();
    step("to_boot", mk(0, 0, 0, 0, 0, C_BOOT, 0, 1, 0, 0));
    step("to_run",  mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step($sformatf("to_wait%0d", i), mk(0, 1, 0, 0, 0, C_MS, 0, 1, i, 0));
    end
    step("to_halt0", mk(0, 1, 0, 0, 0, C_HLT, 1, 1, 5, 0));
    step("to_halt1", mk(0, 0, 1, 1, 1, C_HLT, 1, 1, 5, 0));
    step("to_halt2", mk(1, 0, 0, 0, 0, C_HLT, 1, 0, 0, 0));

    // Reset while in MEM_WAIT
    do_reset();
    step("rw_boot", mk(0, 0, 0, 0, 0, C_BOOT, 0, 1, 0, 0));
    step("rw_run",  mk(0, 0, 0, 1, 0, C_BR,   0, 1, 0, 0));
    step("rw_ms0",  mk(0, 1, 0, 0, 0, C_MS,   0, 1, 0, 1));
    step("rw_ms1",  mk(0, 1, 0, 0, 0, C_MS,   0, 1, 1, 1));
    do_reset();
    step("rw_boot2", mk(0, 0, 0, 0, 0, C_BOOT, 0, 1, 0, 0));
    step("rw_run2",  mk(0, 0, 0, 0, 0, C_NORM, 0, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It consumes hazard requests (load-use stall, multi-cycle data-memory handshake, taken-branch redirect, halt) and drives the per-stage enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sits beside the hazard detection unit and applies that unit's stall request to the pipeline registers, arbitrating it against memory wait states and control-flow flushes.

## Interface
- MEM_TIMEOUT, 200: max cycles spent in MEM_WAIT before declaring a bus fault; 0 disables the timeout
- TO_W, 8: width of the timeout counter; MEM_TIMEOUT must be < 2^TO_W
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_load_use  in  1  load-use stall request from the hazard unit
- i_dmem_req  in  1  MEM stage holds a valid load/store this cycle
- i_dmem_ack  in  1  data memory completes the access this cycle
- i_branch_taken  in  1  EX stage resolves a taken branch/jump (redirect PC)
- i_halt  in  1  WB stage retires EBREAK/ECALL
- o_pc_en  out  1  PC register update enable
- o_if_id_en  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID cleared to NOP
- o_id_ex_en  out  1  ID/EX load enable
- o_id_ex_bubble  out  1  ID/EX loaded with NOP
- o_ex_mem_en  out  1  EX/MEM load enable
- o_mem_wb_bubble  out  1  MEM/WB loaded with NOP
- o_halted  out  1  core halted (sticky until reset)
- o_mem_timeout  out  1  halt caused by memory timeout (sticky until reset)
- o_stall_cycles  out  32  cycles with o_pc_en=0 while not halted/booting
- o_flush_count  out  32  number of branch flushes applied

## Operation
- States: BOOT, RUN, MEM_WAIT, HALTED. Reset (i_rst_n=0 at an edge) forces BOOT, clears timeout counter, o_halted, o_mem_timeout and perf counters.
- Outputs are Mealy: a function of state and current-cycle inputs.
- BOOT: all enables 0, o_if_id_flush=1, o_id_ex_bubble=1, o_mem_wb_bubble=1. Next state RUN unconditionally.
- RUN, evaluated in priority order:
  1. i_halt: all enables 0, bubbles/flush 0; next HALTED.
  2. i_dmem_req && !i_dmem_ack (memory stall): o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en = 0; o_mem_wb_bubble=1; next MEM_WAIT. A concurrent branch or load-use is ignored; it is re-presented because EX/ID are frozen.
  3. i_branch_taken: o_pc_en=1, o_if_id_flush=1, o_id_ex_bubble=1, other enables 1; i_load_use ignored (its consumer is squashed).
  4. i_load_use: o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_ex_mem_en=1.
  5. Otherwise: all enables 1, flush/bubbles 0.
- MEM_WAIT: timeout counter increments each cycle.
  - i_dmem_ack=0: same outputs as the memory-stall case.
  - i_dmem_ack=1: outputs computed as RUN rules 3-5 (the frozen branch/load-use now resolves); next RUN; counter cleared.
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT-1 with no ack: next HALTED, o_mem_timeout set.
- HALTED: all enables 0, flush/bubbles 0, o_halted=1. Exit only via reset.
- i_halt in MEM_WAIT is ignored (WB holds a bubble there).

## Timing
- Zero-cycle control latency: a request in cycle N affects the register loads at the end of cycle N.
- Load-use costs exactly 1 cycle; a taken branch costs 2 bubbles (IF/ID + ID/EX).
- A memory access acked in the cycle of the request costs 0 cycles; otherwise stall length = cycles until ack.
- o_halted and o_mem_timeout are registered: asserted the cycle after the transition.
- Counters wrap modulo 2^32.

## Configuration
- PIPE_CTRL_PERF_EN defined: o_stall_cycles increments each RUN/MEM_WAIT cycle with o_pc_en=0; o_flush_count increments each cycle rule 3 fires (including on ack in MEM_WAIT).
- Undefined: both counter ports tied to 32'd0 and no counter flops are synthesized; all other behaviour is identical.

## Test plan
- Reset, then release i_rst_n: first cycle shows BOOT outputs (enables 0, flush/bubbles 1); second cycle all enables 1, o_halted=0.
- i_load_use=1 for one cycle in RUN -> o_pc_en=0, o_if_id_en=0, o_id_ex_bubble=1, o_ex_mem_en=1; next cycle normal; o_stall_cycles=1 with PERF_EN.
- i_dmem_req=1, i_dmem_ack low for 3 cycles then high, i_branch_taken=1 throughout -> 3 frozen cycles with o_mem_wb_bubble=1, then an ack cycle with o_if_id_flush=1, o_id_ex_bubble=1; o_flush_count=1.
- i_branch_taken and i_load_use together in RUN -> o_pc_en=1, o_if_id_flush=1, o_id_ex_bubble=1 (branch wins).
- MEM_TIMEOUT=4, i_dmem_req=1, ack never -> 4 stall cycles, then o_halted=1 and o_mem_timeout=1 remain set until reset.
- i_halt=1 in RUN -> next cycle o_halted=1, all enables 0; reset mid-MEM_WAIT returns the block to BOOT and clears the counters.
